// File: rtl/ctrl_decoder_if.sv
// Bus bundle between the fetch/decode/execute controller and its instruction
// memory, data memory and combinational ALU.
interface ctrl_decoder_if;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_valid;
  logic [15:0] imem_rdata;
  logic        dmem_req;
  logic        dmem_we;
  logic [15:0] dmem_addr;
  logic [15:0] dmem_wdata;
  logic        dmem_ack;
  logic [15:0] dmem_rdata;
  logic [2:0]  alu_opr;
  logic [15:0] alu_x;
  logic [15:0] alu_y;
  logic [15:0] alu_result;
  logic        alu_z;

  modport master (
    output imem_req, imem_addr, dmem_req, dmem_we, dmem_addr, dmem_wdata,
           alu_opr, alu_x, alu_y,
    input  imem_valid, imem_rdata, dmem_ack, dmem_rdata, alu_result, alu_z
  );

  modport slave (
    input  imem_req, imem_addr, dmem_req, dmem_we, dmem_addr, dmem_wdata,
           alu_opr, alu_x, alu_y,
    output imem_valid, imem_rdata, dmem_ack, dmem_rdata, alu_result, alu_z
  );
endinterface

// File: rtl/ctrl_decoder.sv
// Multi-cycle fetch/decode/execute controller for the 16-bit RISC core: owns the
// PC, the 8x16 register file and the instruction/data memory handshakes.
module ctrl_decoder #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic           clk,
  input  logic           rst_n,
  ctrl_decoder_if.master bus,
  output logic [15:0]    pc,
  output logic           instr_done,
  output logic           illegal
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] pc_q, ir_q;
  logic [2:0]  opr_q;
  logic [15:0] x_q, y_q, result_q, dmem_addr_q, dmem_wdata_q;
  logic        dmem_we_q, z_q;
  logic [15:0] regs_q [8];

  // Instruction fields
  logic [3:0]  opcode;
  logic [2:0]  rd, rs, rt;
  logic [15:0] imm16;
  logic [15:0] r_rd, r_rs, r_rt;

  assign opcode = ir_q[15:12];
  assign rd     = ir_q[11:9];
  assign rs     = ir_q[8:6];
  assign rt     = ir_q[5:3];
  assign imm16  = {{10{ir_q[5]}}, ir_q[5:0]};

  // R0 reads as zero no matter what the array holds
  assign r_rd = (rd == 3'd0) ? 16'h0000 : regs_q[rd];
  assign r_rs = (rs == 3'd0) ? 16'h0000 : regs_q[rs];
  assign r_rt = (rt == 3'd0) ? 16'h0000 : regs_q[rt];

  logic        is_load, is_store, is_branch, is_jump, is_illegal, writes_rd;
  logic [2:0]  dec_opr;
  logic [15:0] dec_x, dec_y;

  assign is_load    = (opcode == 4'hA);
  assign is_store   = (opcode == 4'hB);
  assign is_branch  = (opcode == 4'h9);
  assign is_jump    = (opcode == 4'hC);
  assign is_illegal = (opcode >= 4'hD);
  assign writes_rd  = (opcode >= 4'h1 && opcode <= 4'h8) || is_load;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    dec_opr = 3'b000;
    dec_x   = 16'h0000;
    dec_y   = 16'h0000;
    case (opcode)
      4'h1, 4'h2, 4'h3, 4'h4, 4'h5: begin
        dec_opr = opcode[2:0];
        dec_x   = r_rs;
        dec_y   = r_rt;
      end
      4'h6: begin
        dec_opr = 3'b110;
        dec_x   = r_rs;
      end
      4'h7: begin
        dec_opr = 3'b111;
        dec_x   = r_rs;
      end
      4'h8, 4'hA, 4'hB: begin
        dec_opr = 3'b001;
        dec_x   = r_rs;
        dec_y   = imm16;
      end
      4'h9: begin
        dec_opr = 3'b010;
        dec_x   = r_rd;
        dec_y   = r_rs;
      end
      default: ;
    endcase
  end

  logic [15:0] pc_inc, pc_next;

  always_comb begin
    pc_inc  = pc_q + 16'd1;
    pc_next = pc_inc;
    if (is_branch && z_q) begin
      pc_next = pc_inc + imm16;
    end else if (is_jump) begin
      pc_next = {pc_q[15:12], ir_q[11:0]};
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   state_d = S_FETCH;
      S_FETCH:  if (bus.imem_valid) state_d = S_DECODE;
      S_DECODE: state_d = S_EXEC;
      S_EXEC:   state_d = (is_load || is_store) ? S_MEM : S_WB;
      S_MEM:    if (bus.dmem_ack) state_d = S_WB;
      S_WB:     state_d = S_FETCH;
      default:  state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the pre-edge values of the others regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      pc_q         <= RESET_PC;
      ir_q         <= '0;
      opr_q        <= '0;
      x_q          <= '0;
      y_q          <= '0;
      result_q     <= '0;
      dmem_addr_q  <= '0;
      dmem_wdata_q <= '0;
      dmem_we_q    <= 1'b0;
      z_q          <= 1'b0;
      // NOTE: the register file is small and must come up zeroed, so it is
      // reset as flops rather than mapped onto a RAM macro.
      for (int i = 0; i < 8; i++) regs_q[i] <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_FETCH: if (bus.imem_valid) ir_q <= bus.imem_rdata;
        S_DECODE: begin
          opr_q     <= dec_opr;
          x_q       <= dec_x;
          y_q       <= dec_y;
          dmem_we_q <= is_store;
          if (is_store) dmem_wdata_q <= r_rd;
        end
        S_EXEC: begin
          result_q <= bus.alu_result;
          z_q      <= bus.alu_z;
          if (is_load || is_store) dmem_addr_q <= bus.alu_result;
        end
        S_MEM: if (bus.dmem_ack && is_load) result_q <= bus.dmem_rdata;
        S_WB: begin
          pc_q <= pc_next;
          if (writes_rd && rd != 3'd0) regs_q[rd] <= result_q;
        end
        default: ;
      endcase
    end
  end

  assign bus.imem_req   = (state_q == S_FETCH);
  assign bus.imem_addr  = pc_q;
  assign bus.dmem_req   = (state_q == S_MEM);
  assign bus.dmem_we    = (state_q == S_MEM) && dmem_we_q;
  assign bus.dmem_addr  = dmem_addr_q;
  assign bus.dmem_wdata = dmem_wdata_q;
  assign bus.alu_opr    = (state_q == S_EXEC) ? opr_q : 3'b000;
  assign bus.alu_x      = x_q;
  assign bus.alu_y      = y_q;
  assign pc             = pc_q;
  assign instr_done     = (state_q == S_WB);
  assign illegal        = (state_q == S_WB) && is_illegal;

endmodule
